// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
// Holds the sequencer state enum, the slice width and the index-width helper.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_WIDTH   = 18;
    localparam int DEFAULT_WORDS = 4;

    // Word index width; never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/rca18_cin.sv
// 18-bit ripple-carry adder slice with carry-in, built as a chain of full adders.
// Purely combinational; the carry between slices is registered by the caller.
module rca18_cin
    import rca_seq_pkg::*;
(
    output logic [SLICE_WIDTH-1:0] s,
    output logic                   co,
    input  logic [SLICE_WIDTH-1:0] x,
    input  logic [SLICE_WIDTH-1:0] y,
    input  logic                   ci
);

    logic [SLICE_WIDTH:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE_WIDTH; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[SLICE_WIDTH];

endmodule

// File: rtl/rca_mp_add_seq.sv
// Multi-precision adder: one 18-bit slice reused LSW-first with a registered carry.
// Optional subtract support is built only when RCA_SEQ_SUB_EN is defined.
//
// state | meaning
// IDLE  | ready for a request; operands latched on accept
// RUN   | one word pair per cycle through the slice, carry chained in a register
// DONE  | result held on rsp_s with rsp_valid until rsp_ready
module rca_mp_add_seq
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = SLICE_WIDTH,
    parameter int WORDS = DEFAULT_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WORDS*WIDTH-1:0] req_x,
    input  logic [WORDS*WIDTH-1:0] req_y,
    input  logic                 req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORDS*WIDTH:0] rsp_s,
    output logic                 busy
);

    localparam int NB = WORDS * WIDTH;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_t          state, state_nxt;
    logic [NB-1:0]   x_sh, y_sh, y_in;
    logic            cin0;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [NB:0]     sum;
    logic [WIDTH-1:0] slice_s;
    logic            slice_co;
    logic            accept, last;

`ifdef RCA_SEQ_SUB_EN
    assign y_in = req_sub ? ~req_y : req_y;
    assign cin0 = req_sub;
`else
    logic unused_sub;
    assign unused_sub = req_sub;
    assign y_in       = req_y;
    assign cin0       = 1'b0;
`endif

    // Operands shift right each RUN cycle, so the slice always reads word 0.
    rca18_cin u_slice (
        .s  (slice_s),
        .co (slice_co),
        .x  (x_sh[WIDTH-1:0]),
        .y  (y_sh[WIDTH-1:0]),
        .ci (carry)
    );

    assign accept = req_valid && req_ready;
    assign last   = (idx == LAST_IDX);
    assign rsp_s  = sum;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: req_ready = !rst;
            RUN:  busy      = 1'b1;
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_sh  <= '0;
            y_sh  <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    x_sh  <= req_x;
                    y_sh  <= y_in;
                    idx   <= '0;
                    carry <= cin0;
                    sum   <= '0;
                end
                RUN: begin
                    sum[int'(idx)*WIDTH +: WIDTH] <= slice_s;
                    carry <= slice_co;
                    idx   <= idx + 1'b1;
                    x_sh  <= x_sh >> WIDTH;
                    y_sh  <= y_sh >> WIDTH;
                    if (last) sum[NB] <= slice_co;
                end
                default: ;
            endcase
        end
    end

endmodule
